pcq_clks_seq: RTL and testbench
===============================

Name: pcq_clks_seq

Overview:
- Core clock start/stop sequencer. It is the upstream driver of the level-7 thold/sg/fce controls that the core clock-control staging distributes to the units.
- On software or hardware request it drops the tholds in a fixed order, with a programmable spacing between steps. It raises them in reverse order on stop.
- It gates scan-gate (sg) and force (fce) so scan is only possible while clocks are stopped.
- It raises all tholds immediately on a fast checkstop.

Parameters:
- STEP_DLY, 8, cycles between consecutive thold transitions; 0 is treated as 1.
- DLY_WIDTH, 4, width of the step-delay counter; must hold STEP_DLY-1.

Ports:
- nclk  in  1  core clock
- nreset  in  1  asynchronous reset, active-low
- start_req  in  1  single-cycle pulse: start clocks
- stop_req  in  1  single-cycle pulse: stop clocks
- scan_req  in  1  level: request scan gate
- fce_req  in  1  level: request force (effective only with sg)
- rg_ck_fast_xstop  in  1  level: fast checkstop
- ary_nsl_thold_7  out  1  array non-scan thold (1 = held)
- func_nsl_thold_7  out  1  functional non-scan thold
- func_sl_thold_7  out  1  functional scan-latch thold
- rtim_sl_thold_7  out  1  retiming thold
- sg_7  out  1  scan gate
- fce_7  out  1  force clock enable
- seq_busy  out  1  sequence in progress
- clks_running  out  1  all tholds low
- seq_done  out  1  one-cycle pulse at end of a start or stop sequence
- xstop_seen  out  1  sticky checkstop indication

Behaviour:
- All outputs are registered.
- Reset values:
  - all four tholds = 1
  - sg_7, fce_7, seq_busy, clks_running, seq_done, xstop_seen = 0
  - state = STOPPED
- FSM states: STOPPED, UP1..UP4, RUNNING, DN1..DN4.
- Start sequence:
  - STOPPED + start_req + scan_req=0 + rg_ck_fast_xstop=0 -> UP1.
  - UP1 drops ary_nsl. After STEP_DLY cycles, UP2 drops func_nsl.
  - After STEP_DLY cycles, UP3 drops func_sl. After STEP_DLY cycles, UP4 drops rtim_sl.
  - After STEP_DLY cycles -> RUNNING, with seq_done pulsed 1 cycle and clks_running=1.
- Stop sequence:
  - RUNNING + stop_req -> DN1.
  - DN1 raises rtim_sl, then func_sl, then func_nsl, then ary_nsl, each after STEP_DLY cycles.
  - After a further STEP_DLY cycles -> STOPPED, with seq_done pulsed.
- Thold timing: a thold changes in the cycle after entering its step state. The delay counter loads STEP_DLY-1 on step entry and decrements to 0.
- seq_busy = 1 in every UPn and DNn state.
- clks_running drops in the cycle DN1 is entered.
- Requests that do not apply to the current state are ignored:
  - start_req while RUNNING or DNn is ignored.
  - stop_req while STOPPED is ignored.
  - start_req while scan_req=1 is ignored.
- stop_req during UPn aborts the start: the sequencer jumps to the DN state that raises the most recently dropped thold (UP1->DN4, UP2->DN3, UP3->DN2, UP4->DN1) and continues the stop normally from there.
- Simultaneous start_req and stop_req: stop wins; while STOPPED both are ignored.
- Scan gating:
  - sg_7 = scan_req registered, forced 0 unless state = STOPPED.
  - fce_7 = sg_7 & fce_req registered.
  - Leaving STOPPED clears sg_7 and fce_7 in the same cycle the state changes.
- Fast checkstop (rg_ck_fast_xstop=1) in any state:
  - next cycle: all tholds = 1, state = STOPPED, seq_busy = 0, clks_running = 0, no seq_done.
  - xstop_seen set; it is held until the next accepted start_req.
  - start_req is blocked while rg_ck_fast_xstop = 1.
- Asynchronous reset mid-sequence returns all outputs to their reset values immediately.

Optional Feature:
- Macro: PCQ_CLKS_SEQ_DLY_OVR_EN.
- Defined: adds inputs dly_ovr_en (1) and dly_ovr_val (DLY_WIDTH).
  - When dly_ovr_en = 1 at step entry, the counter loads dly_ovr_val instead of STEP_DLY-1.
  - A value of 0 gives 1-cycle spacing.
  - The value is sampled only at step entry; a change mid-step has no effect.
- Undefined: the ports are absent and the spacing is always STEP_DLY.

Test Plan:
- Reset, then start_req pulse at cycle 0 (STEP_DLY=8):
  - ary_nsl falls at cycle 2, func_nsl at 10, func_sl at 18, rtim_sl at 26.
  - seq_done pulses and clks_running = 1 at cycle 34.
- From RUNNING, stop_req: tholds rise in the order rtim_sl, func_sl, func_nsl, ary_nsl, 8 cycles apart; seq_done pulses; sg_7 stays 0 throughout.
- stop_req issued 3 cycles after func_nsl drops (state UP2): func_nsl rises, then ary_nsl; func_sl and rtim_sl never fall; final state STOPPED.
- rg_ck_fast_xstop pulsed mid-UP3:
  - next cycle all tholds = 1, seq_busy = 0, xstop_seen = 1.
  - a following start_req with xstop low restarts the sequence and clears xstop_seen.
- scan_req=1, fce_req=1 in STOPPED: sg_7 = 1 then fce_7 = 1; start_req is ignored. scan_req=1 while RUNNING: sg_7 stays 0.
- With PCQ_CLKS_SEQ_DLY_OVR_EN defined, dly_ovr_en=1, dly_ovr_val=2: consecutive thold transitions are spaced 3 cycles apart.

Source files
------------

// File: rtl/pcq_clks_seq_if.sv
// Request/status bundle between the clock-control driver and pcq_clks_seq.
// Optional macro: PCQ_CLKS_SEQ_DLY_OVR_EN adds the step-delay override signals.
interface pcq_clks_seq_if #(
    parameter int DLY_WIDTH = 4
);
    logic                 start_req;
    logic                 stop_req;
    logic                 scan_req;
    logic                 fce_req;
    logic                 rg_ck_fast_xstop;
`ifdef PCQ_CLKS_SEQ_DLY_OVR_EN
    logic                 dly_ovr_en;
    logic [DLY_WIDTH-1:0] dly_ovr_val;
`endif
    logic                 ary_nsl_thold_7;
    logic                 func_nsl_thold_7;
    logic                 func_sl_thold_7;
    logic                 rtim_sl_thold_7;
    logic                 sg_7;
    logic                 fce_7;
    logic                 seq_busy;
    logic                 clks_running;
    logic                 seq_done;
    logic                 xstop_seen;

    modport master (
`ifdef PCQ_CLKS_SEQ_DLY_OVR_EN
        output dly_ovr_en,
        output dly_ovr_val,
`endif
        output start_req,
        output stop_req,
        output scan_req,
        output fce_req,
        output rg_ck_fast_xstop,
        input  ary_nsl_thold_7,
        input  func_nsl_thold_7,
        input  func_sl_thold_7,
        input  rtim_sl_thold_7,
        input  sg_7,
        input  fce_7,
        input  seq_busy,
        input  clks_running,
        input  seq_done,
        input  xstop_seen
    );

    modport slave (
`ifdef PCQ_CLKS_SEQ_DLY_OVR_EN
        input  dly_ovr_en,
        input  dly_ovr_val,
`endif
        input  start_req,
        input  stop_req,
        input  scan_req,
        input  fce_req,
        input  rg_ck_fast_xstop,
        output ary_nsl_thold_7,
        output func_nsl_thold_7,
        output func_sl_thold_7,
        output rtim_sl_thold_7,
        output sg_7,
        output fce_7,
        output seq_busy,
        output clks_running,
        output seq_done,
        output xstop_seen
    );
endinterface

// File: rtl/pcq_clks_seq.sv
// Core clock start/stop sequencer driving the level-7 thold/sg/fce controls.
// Tholds drop in order ary_nsl, func_nsl, func_sl, rtim_sl on start and rise
// in reverse on stop, one step every STEP_DLY cycles. A fast checkstop raises
// all tholds at once. Scan gate / force are only passed while stopped.
// Optional macro: PCQ_CLKS_SEQ_DLY_OVR_EN adds a per-step delay override.
module pcq_clks_seq #(
    parameter int STEP_DLY  = 8,
    parameter int DLY_WIDTH = 4
) (
    input  logic              nclk,
    input  logic              nreset,
    pcq_clks_seq_if.slave     bus
);

    typedef enum logic [3:0] {
        ST_STOPPED,
        ST_UP1,
        ST_UP2,
        ST_UP3,
        ST_UP4,
        ST_RUNNING,
        ST_DN1,
        ST_DN2,
        ST_DN3,
        ST_DN4
    } state_t;

    localparam logic [DLY_WIDTH-1:0] DLY_LOAD =
        (STEP_DLY <= 1) ? '0 : DLY_WIDTH'(STEP_DLY - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DLY_WIDTH-1:0] r_cnt;
    logic [DLY_WIDTH-1:0] w_dly_load;
    logic                 w_step_done;
    logic                 w_start_ok;
    logic                 w_entry;
    logic                 w_done_evt;
    logic                 w_xstop;
    logic [3:0]           w_thold;      // {ary_nsl, func_nsl, func_sl, rtim_sl}

    logic [3:0]           r_thold;
    logic                 r_sg;
    logic                 r_fce;
    logic                 r_busy;
    logic                 r_running;
    logic                 r_done_pend;
    logic                 r_seq_done;
    logic                 r_xstop_seen;

    assign w_xstop     = bus.rg_ck_fast_xstop;
    assign w_step_done = (r_cnt == '0);
    assign w_start_ok  = bus.start_req & ~bus.stop_req & ~bus.scan_req & ~w_xstop;

    // Step delay reload value, optionally overridden at step entry.
    always_comb begin
        w_dly_load = DLY_LOAD;
`ifdef PCQ_CLKS_SEQ_DLY_OVR_EN
        if (bus.dly_ovr_en) begin
            w_dly_load = bus.dly_ovr_val;
        end
`endif
    end

    // Next-state: stop aborts a start by jumping to the DN step that re-raises
    // the most recently dropped thold; checkstop overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        if (w_xstop) begin
            w_state_nxt = ST_STOPPED;
        end else begin
            case (r_state)
                ST_STOPPED: if (w_start_ok)   w_state_nxt = ST_UP1;
                ST_UP1: begin
                    if (bus.stop_req)         w_state_nxt = ST_DN4;
                    else if (w_step_done)     w_state_nxt = ST_UP2;
                end
                ST_UP2: begin
                    if (bus.stop_req)         w_state_nxt = ST_DN3;
                    else if (w_step_done)     w_state_nxt = ST_UP3;
                end
                ST_UP3: begin
                    if (bus.stop_req)         w_state_nxt = ST_DN2;
                    else if (w_step_done)     w_state_nxt = ST_UP4;
                end
                ST_UP4: begin
                    if (bus.stop_req)         w_state_nxt = ST_DN1;
                    else if (w_step_done)     w_state_nxt = ST_RUNNING;
                end
                ST_RUNNING: if (bus.stop_req) w_state_nxt = ST_DN1;
                ST_DN1: if (w_step_done)      w_state_nxt = ST_DN2;
                ST_DN2: if (w_step_done)      w_state_nxt = ST_DN3;
                ST_DN3: if (w_step_done)      w_state_nxt = ST_DN4;
                ST_DN4: if (w_step_done)      w_state_nxt = ST_STOPPED;
                default:                      w_state_nxt = ST_STOPPED;
            endcase
        end
    end

    // Step entry and sequence-completion events derived from the transition.
    always_comb begin
        w_entry    = (w_state_nxt != r_state) &&
                     (w_state_nxt != ST_STOPPED) && (w_state_nxt != ST_RUNNING);
        w_done_evt = ~w_xstop &&
                     (((r_state == ST_UP4) && (w_state_nxt == ST_RUNNING)) ||
                      ((r_state == ST_DN4) && (w_state_nxt == ST_STOPPED)));
    end

    // Thold levels held in each state; applied one cycle after state entry.
    always_comb begin
        w_thold = 4'b1111;
        case (r_state)
            ST_STOPPED: w_thold = 4'b1111;
            ST_UP1:     w_thold = 4'b0111;
            ST_UP2:     w_thold = 4'b0011;
            ST_UP3:     w_thold = 4'b0001;
            ST_UP4:     w_thold = 4'b0000;
            ST_RUNNING: w_thold = 4'b0000;
            ST_DN1:     w_thold = 4'b0001;
            ST_DN2:     w_thold = 4'b0011;
            ST_DN3:     w_thold = 4'b0111;
            ST_DN4:     w_thold = 4'b1111;
            default:    w_thold = 4'b1111;
        endcase
    end

    // State register and step-delay counter.
    always_ff @(posedge nclk or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_STOPPED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_entry) begin
                r_cnt <= w_dly_load;
            end else if (!w_step_done) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Registered outputs. clks_running rises one cycle after RUNNING is
    // entered but drops in the same cycle DN1 (or STOPPED) is entered.
    always_ff @(posedge nclk or negedge nreset) begin
        if (!nreset) begin
            r_thold      <= 4'b1111;
            r_sg         <= 1'b0;
            r_fce        <= 1'b0;
            r_busy       <= 1'b0;
            r_running    <= 1'b0;
            r_done_pend  <= 1'b0;
            r_seq_done   <= 1'b0;
            r_xstop_seen <= 1'b0;
        end else begin
            r_thold      <= w_xstop ? 4'b1111 : w_thold;
            r_sg         <= bus.scan_req & (w_state_nxt == ST_STOPPED);
            r_fce        <= r_sg & bus.fce_req & (w_state_nxt == ST_STOPPED);
            r_busy       <= (w_state_nxt != ST_STOPPED) && (w_state_nxt != ST_RUNNING);
            r_running    <= (r_state == ST_RUNNING) && (w_state_nxt == ST_RUNNING);
            r_done_pend  <= w_done_evt;
            r_seq_done   <= r_done_pend & ~w_xstop;
            if (w_xstop) begin
                r_xstop_seen <= 1'b1;
            end else if ((r_state == ST_STOPPED) && w_start_ok) begin
                r_xstop_seen <= 1'b0;
            end
        end
    end

    assign bus.ary_nsl_thold_7  = r_thold[3];
    assign bus.func_nsl_thold_7 = r_thold[2];
    assign bus.func_sl_thold_7  = r_thold[1];
    assign bus.rtim_sl_thold_7  = r_thold[0];
    assign bus.sg_7             = r_sg;
    assign bus.fce_7            = r_fce;
    assign bus.seq_busy         = r_busy;
    assign bus.clks_running     = r_running;
    assign bus.seq_done         = r_seq_done;
    assign bus.xstop_seen       = r_xstop_seen;

endmodule

// File: tb/tb_pcq_clks_seq.sv
// Directed bench for pcq_clks_seq with STEP_DLY = 8.
// Cycle numbering: a request driven before edge 0 is seen by the DUT at edge 0;
// "cycle c" is the interval after edge c-1, sampled on the falling edge.
module tb_pcq_clks_seq;

    logic nclk = 1'b0;
    logic nreset;
    int   total = 0;
    int   bad   = 0;

    // Per-watch observations.
    int   t_chg [4];
    int   done_cnt, done_cyc, run_cyc;
    logic sg_seen, busy_seen, run1, busy1;

    pcq_clks_seq_if #(.DLY_WIDTH(4)) bus ();

    pcq_clks_seq #(.STEP_DLY(8), .DLY_WIDTH(4)) dut (
        .nclk   (nclk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 nclk = ~nclk;

    function automatic logic [3:0] tholds();
        return {bus.ary_nsl_thold_7, bus.func_nsl_thold_7,
                bus.func_sl_thold_7, bus.rtim_sl_thold_7};
    endfunction

    function automatic logic [5:0] status();
        return {bus.sg_7, bus.fce_7, bus.seq_busy, bus.clks_running,
                bus.seq_done, bus.xstop_seen};
    endfunction

    // Run ncyc cycles, clearing pulse requests and logging when each thold
    // first departs from init, plus done / running / scan observations.
    task automatic watch(input int ncyc, input logic [3:0] init);
        logic [3:0] w;
        for (int b = 0; b < 4; b++) t_chg[b] = -1;
        done_cnt = 0; done_cyc = -1; run_cyc = -1;
        sg_seen = 1'b0; busy_seen = 1'b0; run1 = 1'b0; busy1 = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge nclk);
            @(negedge nclk);
            bus.start_req = 1'b0;
            bus.stop_req  = 1'b0;
            w = tholds();
            for (int b = 0; b < 4; b++)
                if (t_chg[b] < 0 && w[b] !== init[b]) t_chg[b] = c;
            if (bus.seq_done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (run_cyc < 0 && bus.clks_running === 1'b1) run_cyc = c;
            if (bus.sg_7 === 1'b1) sg_seen = 1'b1;
            if (bus.seq_busy === 1'b1) busy_seen = 1'b1;
            if (c == 1) begin
                run1  = bus.clks_running;
                busy1 = bus.seq_busy;
            end
        end
    endtask

    task automatic cycle1();
        @(posedge nclk);
        @(negedge nclk);
    endtask

    task automatic test_reset();
        bus.start_req = 0; bus.stop_req = 0; bus.scan_req = 0;
        bus.fce_req = 0; bus.rg_ck_fast_xstop = 0;
`ifdef PCQ_CLKS_SEQ_DLY_OVR_EN
        bus.dly_ovr_en = 0; bus.dly_ovr_val = '0;
`endif
        nreset = 1'b0;
        cycle1(); cycle1();
        total++; if (tholds() !== 4'b1111) begin bad++;
            $display("FAIL reset_tholds got=%b exp=1111", tholds()); end
        total++; if (status() !== 6'b000000) begin bad++;
            $display("FAIL reset_status got=%b exp=000000", status()); end
        nreset = 1'b1;
        cycle1(); cycle1();
        total++; if ({tholds(), status()} !== 10'b1111_000000) begin bad++;
            $display("FAIL post_reset got=%b exp=1111000000", {tholds(), status()}); end
    endtask

    task automatic test_start();
        bus.start_req = 1'b1;
        watch(40, 4'b1111);
        total++; if (busy1 !== 1'b1) begin bad++;
            $display("FAIL start_busy_c1 got=%b exp=1", busy1); end
        total++; if (t_chg[3] != 2) begin bad++;
            $display("FAIL start_ary got=%0d exp=2", t_chg[3]); end
        total++; if (t_chg[2] != 10) begin bad++;
            $display("FAIL start_fnsl got=%0d exp=10", t_chg[2]); end
        total++; if (t_chg[1] != 18) begin bad++;
            $display("FAIL start_fsl got=%0d exp=18", t_chg[1]); end
        total++; if (t_chg[0] != 26) begin bad++;
            $display("FAIL start_rtim got=%0d exp=26", t_chg[0]); end
        total++; if (done_cyc != 34 || done_cnt != 1) begin bad++;
            $display("FAIL start_done cyc=%0d cnt=%0d exp=34/1", done_cyc, done_cnt); end
        total++; if (run_cyc != 34) begin bad++;
            $display("FAIL start_running got=%0d exp=34", run_cyc); end
        total++; if (bus.seq_busy !== 1'b0) begin bad++;
            $display("FAIL start_busy_end got=%b exp=0", bus.seq_busy); end
    endtask

    task automatic test_ignored_requests();
        // start while RUNNING
        bus.start_req = 1'b1;
        watch(5, 4'b0000);
        total++; if (busy_seen !== 1'b0 || tholds() !== 4'b0000) begin bad++;
            $display("FAIL start_in_running busy=%b th=%b exp=0/0000", busy_seen, tholds()); end
    endtask

    task automatic test_stop();
        bus.stop_req = 1'b1;
        watch(40, 4'b0000);
        total++; if (run1 !== 1'b0 || busy1 !== 1'b1) begin bad++;
            $display("FAIL stop_c1 run=%b busy=%b exp=0/1", run1, busy1); end
        total++; if (t_chg[0] != 2 || t_chg[1] != 10 || t_chg[2] != 18 || t_chg[3] != 26) begin bad++;
            $display("FAIL stop_order rtim=%0d fsl=%0d fnsl=%0d ary=%0d exp=2/10/18/26",
                     t_chg[0], t_chg[1], t_chg[2], t_chg[3]); end
        total++; if (done_cyc != 34 || done_cnt != 1) begin bad++;
            $display("FAIL stop_done cyc=%0d cnt=%0d exp=34/1", done_cyc, done_cnt); end
        total++; if (sg_seen !== 1'b0) begin bad++;
            $display("FAIL stop_sg got=%b exp=0", sg_seen); end
        // stop alone and start+stop together while STOPPED are ignored
        bus.stop_req = 1'b1;
        watch(3, 4'b1111);
        bus.start_req = 1'b1; bus.stop_req = 1'b1;
        watch(4, 4'b1111);
        total++; if (busy_seen !== 1'b0 || tholds() !== 4'b1111) begin bad++;
            $display("FAIL both_in_stopped busy=%b th=%b exp=0/1111", busy_seen, tholds()); end
    endtask

    task automatic test_abort();
        bus.start_req = 1'b1;
        watch(12, 4'b1111);
        total++; if (t_chg[2] != 10) begin bad++;
            $display("FAIL abort_fnsl_fall got=%0d exp=10", t_chg[2]); end
        bus.stop_req = 1'b1;
        watch(24, 4'b0011);
        total++; if (t_chg[2] != 2 || t_chg[3] != 10) begin bad++;
            $display("FAIL abort_rise fnsl=%0d ary=%0d exp=2/10", t_chg[2], t_chg[3]); end
        total++; if (t_chg[1] != -1 || t_chg[0] != -1) begin bad++;
            $display("FAIL abort_fsl_rtim fsl=%0d rtim=%0d exp=-1/-1", t_chg[1], t_chg[0]); end
        total++; if (done_cyc != 18 || bus.seq_busy !== 1'b0 || tholds() !== 4'b1111) begin bad++;
            $display("FAIL abort_end done=%0d busy=%b th=%b exp=18/0/1111",
                     done_cyc, bus.seq_busy, tholds()); end
    endtask

    task automatic test_xstop();
        bus.start_req = 1'b1;
        watch(19, 4'b1111);
        total++; if (t_chg[1] != 18) begin bad++;
            $display("FAIL xs_in_up3 got=%0d exp=18", t_chg[1]); end
        bus.rg_ck_fast_xstop = 1'b1;
        cycle1();
        bus.rg_ck_fast_xstop = 1'b0;
        total++; if (tholds() !== 4'b1111) begin bad++;
            $display("FAIL xs_tholds got=%b exp=1111", tholds()); end
        total++; if (status() !== 6'b000001) begin bad++;
            $display("FAIL xs_status got=%b exp=000001", status()); end
        watch(12, 4'b1111);
        total++; if (done_cnt != 0 || busy_seen !== 1'b0) begin bad++;
            $display("FAIL xs_quiet done=%0d busy=%b exp=0/0", done_cnt, busy_seen); end
        // start blocked while checkstop is high
        bus.rg_ck_fast_xstop = 1'b1; bus.start_req = 1'b1;
        watch(3, 4'b1111);
        bus.rg_ck_fast_xstop = 1'b0;
        cycle1();
        total++; if (busy_seen !== 1'b0 || bus.xstop_seen !== 1'b1) begin bad++;
            $display("FAIL xs_block busy=%b seen=%b exp=0/1", busy_seen, bus.xstop_seen); end
        bus.start_req = 1'b1;
        watch(3, 4'b1111);
        total++; if (t_chg[3] != 2 || bus.xstop_seen !== 1'b0) begin bad++;
            $display("FAIL xs_restart ary=%0d seen=%b exp=2/0", t_chg[3], bus.xstop_seen); end
    endtask

    task automatic test_async_reset();
        // Sequence is in UP1 here with ary_nsl already dropped.
        #2 nreset = 1'b0;
        #1;
        total++; if ({tholds(), status()} !== 10'b1111_000000) begin bad++;
            $display("FAIL async_reset got=%b exp=1111000000", {tholds(), status()}); end
        @(negedge nclk);
        nreset = 1'b1;
        watch(12, 4'b1111);
        total++; if (busy_seen !== 1'b0 || t_chg[3] != -1) begin bad++;
            $display("FAIL async_reset_idle busy=%b ary=%0d exp=0/-1", busy_seen, t_chg[3]); end
    endtask

    task automatic test_scan();
        bus.scan_req = 1'b1; bus.fce_req = 1'b1;
        cycle1();
        total++; if (bus.sg_7 !== 1'b1 || bus.fce_7 !== 1'b0) begin bad++;
            $display("FAIL scan_sg sg=%b fce=%b exp=1/0", bus.sg_7, bus.fce_7); end
        cycle1();
        total++; if (bus.fce_7 !== 1'b1) begin bad++;
            $display("FAIL scan_fce got=%b exp=1", bus.fce_7); end
        bus.start_req = 1'b1;
        watch(4, 4'b1111);
        total++; if (busy_seen !== 1'b0 || bus.sg_7 !== 1'b1) begin bad++;
            $display("FAIL scan_start_ign busy=%b sg=%b exp=0/1", busy_seen, bus.sg_7); end
        bus.scan_req = 1'b0; bus.fce_req = 1'b0;
        bus.start_req = 1'b1;
        watch(36, 4'b1111);
        total++; if (run_cyc != 34 || bus.sg_7 !== 1'b0) begin bad++;
            $display("FAIL scan_clear_run run=%0d sg=%b exp=34/0", run_cyc, bus.sg_7); end
        bus.scan_req = 1'b1; bus.fce_req = 1'b1;
        watch(4, 4'b0000);
        total++; if (sg_seen !== 1'b0 || bus.fce_7 !== 1'b0) begin bad++;
            $display("FAIL scan_running sg=%b fce=%b exp=0/0", sg_seen, bus.fce_7); end
        bus.scan_req = 1'b0; bus.fce_req = 1'b0;
    endtask

`ifdef PCQ_CLKS_SEQ_DLY_OVR_EN
    task automatic test_dly_ovr();
        nreset = 1'b0;
        cycle1();
        nreset = 1'b1;
        cycle1();
        bus.dly_ovr_en = 1'b1; bus.dly_ovr_val = 4'd2;
        bus.start_req = 1'b1;
        watch(16, 4'b1111);
        total++; if (t_chg[3] != 2 || t_chg[2] != 5 || t_chg[1] != 8 || t_chg[0] != 11) begin bad++;
            $display("FAIL ovr_spacing ary=%0d fnsl=%0d fsl=%0d rtim=%0d exp=2/5/8/11",
                     t_chg[3], t_chg[2], t_chg[1], t_chg[0]); end
        total++; if (done_cyc != 14) begin bad++;
            $display("FAIL ovr_done got=%0d exp=14", done_cyc); end
        bus.dly_ovr_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_ignored_requests();
        test_stop();
        test_abort();
        test_xstop();
        test_async_reset();
        test_scan();
`ifdef PCQ_CLKS_SEQ_DLY_OVR_EN
        test_dly_ovr();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
